mc_control_fsm: RTL

//  Multi-cycle MIPS main control FSM. Sequences each instruction through fetch/decode/execute/mem/writeback.

---
 rtl/mc_ctrl_pkg.sv | 95 +++++++++
 rtl/mc_ctrl_out_decode.sv | 99 +++++++++
 rtl/mc_control_fsm.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mc_ctrl_pkg
//   Shared definitions for the multi-cycle MIPS main control FSM:
//   state codes, opcode constants, datapath mux encodings, the packed
//   control vector and the opcode dispatch helper.
//
//   Optional feature macro: MC_CTRL_BNE_EN (adds bne to the dispatch table).
// ----------------------------------------------------------------------------
package mc_ctrl_pkg;

    // FSM state codes; 13..15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10,
        ST_ADDIEX = 4'd11,
        ST_ADDIWB = 4'd12
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // PC-source mux select (11 is never driven)
    localparam logic [1:0] PCSRC_ALU    = 2'b00;  // PC + 4 straight from the ALU
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;  // branch target held in ALUOut
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;  // jump target

    // ALU operand B select
    localparam logic [1:0] ALUB_REGB    = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Complete set of datapath controls produced each cycle.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    // State entered after DECODE for a given opcode. Unsupported opcodes
    // map to FETCH, which is also how the illegal-opcode pulse is detected.
    function automatic state_t dispatch_state(input logic [5:0] op);
        state_t st;
        st = ST_FETCH;
        case (op)
            OP_LW, OP_SW: st = ST_MEMADR;
            OP_RTYPE:     st = ST_EXEC;
            OP_BEQ:       st = ST_BRANCH;
`ifdef MC_CTRL_BNE_EN
            OP_BNE:       st = ST_BRANCH;
`endif
            OP_J:         st = ST_JUMP;
            OP_ADDI:      st = ST_ADDIEX;
            default:      st = ST_FETCH;
        endcase
        return st;
    endfunction

    function automatic logic is_legal_op(input logic [5:0] op);
        return dispatch_state(op) != ST_FETCH;
    endfunction

endpackage

// File: rtl/mc_ctrl_out_decode.sv
// ----------------------------------------------------------------------------
// mc_ctrl_out_decode
//   Combinational output decoder for the multi-cycle control FSM. Controls
//   are a function of the current state only, except that FETCH gates its
//   PC/IR loads with mem_ready and DECODE flags unsupported opcodes.
//
//   Ports
//     i_state      in   state_t  current FSM state
//     i_mem_ready  in   1        memory handshake
//     i_opcode     in   6        IR[31:26]
//     o_ctrl       out  ctrl_t   full control vector
//
//   Optional feature macro: MC_CTRL_BNE_EN (drives branch_ne for bne).
// ----------------------------------------------------------------------------
module mc_ctrl_out_decode
    import mc_ctrl_pkg::*;
(
    input  state_t      i_state,
    input  logic        i_mem_ready,
    input  logic [5:0]  i_opcode,
    output ctrl_t       o_ctrl
);

    always_comb begin
        // NOTE: every field is defaulted to zero before the case so that no
        // path leaves a field unassigned, which would infer a latch.
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.iord      = 1'b0;
                o_ctrl.alu_src_a = 1'b0;
                o_ctrl.alu_src_b = ALUB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
                // A stalled fetch must not advance the PC or reload the IR.
                o_ctrl.pc_write  = i_mem_ready;
                o_ctrl.ir_write  = i_mem_ready;
            end
            ST_DECODE: begin
                // Precompute the branch target into ALUOut.
                o_ctrl.alu_src_a  = 1'b0;
                o_ctrl.alu_src_b  = ALUB_IMM_SH2;
                o_ctrl.alu_op     = ALUOP_ADD;
                o_ctrl.illegal_op = ~is_legal_op(i_opcode);
            end
            ST_MEMADR, ST_ADDIEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMRD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            ST_MEMWR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            ST_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_dst    = 1'b0;
            end
            ST_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUB_REGB;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = 1'b1;
                o_ctrl.mem_to_reg = 1'b0;
            end
            ST_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = ALUB_REGB;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
`ifdef MC_CTRL_BNE_EN
                // IR is held through BRANCH, so the opcode still names the branch.
                o_ctrl.branch_ne     = (i_opcode == OP_BNE);
`endif
            end
            ST_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
            ST_ADDIWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = 1'b0;
                o_ctrl.mem_to_reg = 1'b0;
            end
            default: o_ctrl = '0;  // RESET and unused codes drive nothing
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// ----------------------------------------------------------------------------
// mc_control_fsm
//   Multi-cycle MIPS main control FSM. Sequences each instruction through
//   fetch / decode / execute / memory / writeback and drives every datapath
//   control, including the 3:1 PC-source mux select.
//
//   Parameters
//     STATE_W        width of state_out (default 4)
//
//   Ports
//     clk            in   1  system clock, rising edge
//     rst_n          in   1  synchronous reset, active low
//     opcode         in   6  IR[31:26]
//     mem_ready      in   1  memory access completes in the cycle it is high
//     pc_write       out  1  unconditional PC load
//     pc_write_cond  out  1  conditional PC load (gated downstream by zero)
//     branch_ne      out  1  invert zero for bne
//     iord           out  1  memory address select (0 PC, 1 ALUOut)
//     mem_read       out  1  memory read strobe
//     mem_write      out  1  memory write strobe
//     ir_write       out  1  IR load
//     mem_to_reg     out  1  writeback select (1 MDR, 0 ALUOut)
//     reg_dst        out  1  destination register (1 rd, 0 rt)
//     reg_write      out  1  register file write enable
//     alu_src_a      out  1  ALU A (0 PC, 1 regA)
//     alu_src_b      out  2  ALU B select
//     alu_op         out  2  ALU operation class
//     pc_source      out  2  PC-source mux select
//     illegal_op     out  1  one-cycle pulse on an unsupported opcode
//     state_out      out  STATE_W  current state (debug)
//
//   Optional feature macro: MC_CTRL_BNE_EN (bne support).
// ----------------------------------------------------------------------------
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               branch_ne,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_out
);

    state_t r_state;
    state_t w_next_state;
    ctrl_t  w_ctrl;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples its pre-edge value regardless of block ordering.
        if (!rst_n) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = ST_FETCH;
        case (r_state)
            ST_RESET:  w_next_state = ST_FETCH;
            ST_FETCH:  w_next_state = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: w_next_state = dispatch_state(opcode);
            // IR is still valid here, so the opcode splits loads from stores.
            ST_MEMADR: w_next_state = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  w_next_state = mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWR:  w_next_state = mem_ready ? ST_FETCH : ST_MEMWR;
            ST_MEMWB:  w_next_state = ST_FETCH;
            ST_EXEC:   w_next_state = ST_ALUWB;
            ST_ALUWB:  w_next_state = ST_FETCH;
            ST_BRANCH: w_next_state = ST_FETCH;
            ST_JUMP:   w_next_state = ST_FETCH;
            ST_ADDIEX: w_next_state = ST_ADDIWB;
            ST_ADDIWB: w_next_state = ST_FETCH;
            default:   w_next_state = ST_FETCH;  // codes 13..15 recover
        endcase
    end

    mc_ctrl_out_decode u_out_decode (
        .i_state     (r_state),
        .i_mem_ready (mem_ready),
        .i_opcode    (opcode),
        .o_ctrl      (w_ctrl)
    );

    assign pc_write      = w_ctrl.pc_write;
    assign pc_write_cond = w_ctrl.pc_write_cond;
    assign branch_ne     = w_ctrl.branch_ne;
    assign iord          = w_ctrl.iord;
    assign mem_read      = w_ctrl.mem_read;
    assign mem_write     = w_ctrl.mem_write;
    assign ir_write      = w_ctrl.ir_write;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign reg_dst       = w_ctrl.reg_dst;
    assign reg_write     = w_ctrl.reg_write;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign alu_op        = w_ctrl.alu_op;
    assign pc_source     = w_ctrl.pc_source;
    assign illegal_op    = w_ctrl.illegal_op;
    assign state_out     = STATE_W'(r_state);

endmodule
